// File: rtl/mips_alu.sv
// 32-bit MIPS-style integer ALU: combinational result and next HI/LO values,
// plus a sticky signed-overflow flag clocked by the parent's inverted stage clock.
module mips_alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT,
  output logic        Overflow_OUT
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBU  = 6'h03;
  localparam logic [5:0] OP_AND   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_NOR   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;
  localparam logic [5:0] OP_LUI   = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11;
  localparam logic [5:0] OP_MULTU = 6'h12;
  localparam logic [5:0] OP_DIV   = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;
  localparam logic [5:0] OP_MFHI  = 6'h15;
  localparam logic [5:0] OP_MFLO  = 6'h16;
  localparam logic [5:0] OP_MTHI  = 6'h17;
  localparam logic [5:0] OP_MTLO  = 6'h18;
  localparam logic [5:0] OP_PASSA = 6'h19;
  localparam logic [5:0] OP_PASSB = 6'h1A;
  localparam logic [5:0] OP_MUL   = 6'h1B;

  logic [31:0]        sum;
  logic [31:0]        diff;
  logic               add_ov;
  logic               sub_ov;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               div_zero;
  logic               div_most_neg;
  logic [4:0]         var_shamt;

  assign sum       = A + B;
  assign diff      = A - B;
  assign add_ov    = (A[31] == B[31]) && (sum[31] != A[31]);
  assign sub_ov    = (A[31] != B[31]) && (diff[31] != A[31]);
  assign var_shamt = A[4:0];

  // Operands are widened first so the low 64 bits of the product are exact.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'h0, A} * {32'h0, B};

  assign div_zero     = (B == 32'h0);
  assign div_most_neg = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign quot_s       = $signed(A) / $signed(B);
  assign rem_s        = $signed(A) % $signed(B);
  assign quot_u       = A / B;
  assign rem_u        = A % B;

  always_comb begin
    aluResult = 32'h0;
    HI_OUT    = HI_IN;
    LO_OUT    = LO_IN;
    case (ALU_control)
      OP_ADD, OP_ADDU: aluResult = sum;
      OP_SUB, OP_SUBU: aluResult = diff;
      OP_AND:   aluResult = A & B;
      OP_OR:    aluResult = A | B;
      OP_XOR:   aluResult = A ^ B;
      OP_NOR:   aluResult = ~(A | B);
      OP_SLT:   aluResult = {31'h0, $signed(A) < $signed(B)};
      OP_SLTU:  aluResult = {31'h0, A < B};
      OP_SLL:   aluResult = B << shiftAmount;
      OP_SRL:   aluResult = B >> shiftAmount;
      OP_SRA:   aluResult = $signed(B) >>> shiftAmount;
      OP_SLLV:  aluResult = B << var_shamt;
      OP_SRLV:  aluResult = B >> var_shamt;
      OP_SRAV:  aluResult = $signed(B) >>> var_shamt;
      OP_LUI:   aluResult = {B[15:0], 16'h0};
      OP_MULT: begin
        HI_OUT = prod_s[63:32];
        LO_OUT = prod_s[31:0];
      end
      OP_MULTU: begin
        HI_OUT = prod_u[63:32];
        LO_OUT = prod_u[31:0];
      end
      OP_DIV: begin
        // The one overflowing quotient is pinned explicitly rather than trusting the divider.
        if (div_most_neg) begin
          HI_OUT = 32'h0;
          LO_OUT = 32'h8000_0000;
        end else if (!div_zero) begin
          HI_OUT = rem_s;
          LO_OUT = quot_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          HI_OUT = rem_u;
          LO_OUT = quot_u;
        end
      end
      OP_MFHI:  aluResult = HI_IN;
      OP_MFLO:  aluResult = LO_IN;
      OP_MTHI:  HI_OUT = A;
      OP_MTLO:  LO_OUT = A;
      OP_PASSA: aluResult = A;
      OP_PASSB: aluResult = B;
      OP_MUL:   aluResult = prod_s[31:0];
      default:  aluResult = 32'h0;
    endcase
  end

  // Sticky: once set, only reset clears it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Overflow_OUT <= 1'b0;
    end else if (((ALU_control == OP_ADD) && add_ov) ||
                 ((ALU_control == OP_SUB) && sub_ov)) begin
      Overflow_OUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu: hand-computed vectors per opcode
// and the sticky overflow flag across clock edges and asynchronous reset.
module tb_mips_alu;

  logic        CLK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] HI_IN;
  logic [31:0] LO_IN;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic        Overflow_OUT;

  int checks;
  int failures;

  mips_alu dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .A            (A),
    .B            (B),
    .ALU_control  (ALU_control),
    .shiftAmount  (shiftAmount),
    .HI_IN        (HI_IN),
    .LO_IN        (LO_IN),
    .aluResult    (aluResult),
    .HI_OUT       (HI_OUT),
    .LO_OUT       (LO_OUT),
    .Overflow_OUT (Overflow_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
    ALU_control = ctl;
    A           = a;
    B           = b;
    shiftAmount = sh;
    HI_IN       = hi;
    LO_IN       = lo;
    #1;
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    apply(6'h01, 32'h0, 32'h0, 5'd0, 32'h1111_1111, 32'h2222_2222);
    #12;
    check("reset_ovf", {31'h0, Overflow_OUT}, 32'h0);
    RESET = 1'b1;

    // Non-overflowing ADD must not set the flag.
    apply(6'h00, 32'h1, 32'h2, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("add_small", aluResult, 32'h3);
    check("add_hi_pass", HI_OUT, 32'h1111_1111);
    check("add_lo_pass", LO_OUT, 32'h2222_2222);
    next_edge();
    check("add_small_ovf", {31'h0, Overflow_OUT}, 32'h0);

    apply(6'h00, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    check("add_ovf_res", aluResult, 32'h8000_0000);
    next_edge();
    check("add_ovf_flag", {31'h0, Overflow_OUT}, 32'h1);
    apply(6'h01, 32'h1, 32'h1, 5'd0, 32'h0, 32'h0);
    next_edge();
    check("ovf_sticky", {31'h0, Overflow_OUT}, 32'h1);

    // Async clear, and combinational path keeps working during reset.
    RESET = 1'b0;
    apply(6'h01, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    check("reset_clr_ovf", {31'h0, Overflow_OUT}, 32'h0);
    check("addu_in_reset", aluResult, 32'h8000_0000);
    next_edge();
    RESET = 1'b1;

    // ADDU and SUBU wrap without flagging.
    apply(6'h03, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 32'h0);
    check("subu_wrap", aluResult, 32'h7FFF_FFFF);
    next_edge();
    check("subu_no_ovf", {31'h0, Overflow_OUT}, 32'h0);
    apply(6'h02, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 32'h0);
    check("sub_ovf_res", aluResult, 32'h7FFF_FFFF);
    next_edge();
    check("sub_ovf_flag", {31'h0, Overflow_OUT}, 32'h1);
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    apply(6'h02, 32'h5, 32'h7, 5'd0, 32'h0, 32'h0);
    check("sub_neg", aluResult, 32'hFFFF_FFFE);
    next_edge();
    check("sub_neg_no_ovf", {31'h0, Overflow_OUT}, 32'h0);

    apply(6'h01, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h0, 32'h0);
    check("addu_wrap", aluResult, 32'h1);
    apply(6'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0, 32'h0);
    check("and", aluResult, 32'hF000_F000);
    apply(6'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0, 32'h0);
    check("or", aluResult, 32'hFFF0_FFF0);
    apply(6'h06, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0, 32'h0);
    check("xor", aluResult, 32'h0FF0_0FF0);
    apply(6'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0, 32'h0);
    check("nor", aluResult, 32'h000F_000F);

    apply(6'h08, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    check("slt_neg", aluResult, 32'h1);
    apply(6'h09, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    check("sltu_big", aluResult, 32'h0);
    apply(6'h08, 32'h5, 32'h5, 5'd0, 32'h0, 32'h0);
    check("slt_equal", aluResult, 32'h0);

    apply(6'h0A, 32'h0, 32'h1, 5'd31, 32'h0, 32'h0);
    check("sll31", aluResult, 32'h8000_0000);
    apply(6'h0B, 32'h0, 32'h8000_0000, 5'd31, 32'h0, 32'h0);
    check("srl31", aluResult, 32'h1);
    apply(6'h0C, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0);
    check("sra4", aluResult, 32'hF800_0000);
    apply(6'h0C, 32'h0, 32'h8000_0000, 5'd0, 32'h0, 32'h0);
    check("sra0", aluResult, 32'h8000_0000);
    apply(6'h0D, 32'h21, 32'h1, 5'd0, 32'h0, 32'h0);
    check("sllv", aluResult, 32'h2);
    apply(6'h0E, 32'h8, 32'hFF00_0000, 5'd0, 32'h0, 32'h0);
    check("srlv", aluResult, 32'h00FF_0000);
    apply(6'h0F, 32'hFFFF_FFE4, 32'h8000_0000, 5'd0, 32'h0, 32'h0);
    check("srav", aluResult, 32'hF800_0000);
    apply(6'h10, 32'h0, 32'hFFFF_ABCD, 5'd0, 32'h0, 32'h0);
    check("lui", aluResult, 32'hABCD_0000);

    apply(6'h11, 32'hFFFF_FFFE, 32'h3, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("mult_hi", HI_OUT, 32'hFFFF_FFFF);
    check("mult_lo", LO_OUT, 32'hFFFF_FFFA);
    check("mult_res", aluResult, 32'h0);
    apply(6'h12, 32'hFFFF_FFFE, 32'h3, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("multu_hi", HI_OUT, 32'h2);
    check("multu_lo", LO_OUT, 32'hFFFF_FFFA);

    apply(6'h13, 32'hFFFF_FFF9, 32'h2, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("div_neg_lo", LO_OUT, 32'hFFFF_FFFD);
    check("div_neg_hi", HI_OUT, 32'hFFFF_FFFF);
    apply(6'h13, 32'h7, 32'hFFFF_FFFE, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("div_negdiv_lo", LO_OUT, 32'hFFFF_FFFD);
    check("div_negdiv_hi", HI_OUT, 32'h1);
    apply(6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("div_minneg_lo", LO_OUT, 32'h8000_0000);
    check("div_minneg_hi", HI_OUT, 32'h0);
    apply(6'h13, 32'h7, 32'h0, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("div_zero_hi", HI_OUT, 32'h1111_1111);
    check("div_zero_lo", LO_OUT, 32'h2222_2222);
    apply(6'h14, 32'hFFFF_FFF9, 32'h2, 5'd0, 32'h1111_1111, 32'h2222_2222);
    check("divu_lo", LO_OUT, 32'h7FFF_FFFC);
    check("divu_hi", HI_OUT, 32'h1);
    apply(6'h14, 32'h7, 32'h0, 5'd0, 32'h3333_3333, 32'h4444_4444);
    check("divu_zero_hi", HI_OUT, 32'h3333_3333);
    check("divu_zero_lo", LO_OUT, 32'h4444_4444);
    check("divu_zero_res", aluResult, 32'h0);

    apply(6'h15, 32'h0, 32'h0, 5'd0, 32'h0000_BEEF, 32'h0000_CAFE);
    check("mfhi", aluResult, 32'h0000_BEEF);
    apply(6'h16, 32'h0, 32'h0, 5'd0, 32'h0000_BEEF, 32'h0000_CAFE);
    check("mflo", aluResult, 32'h0000_CAFE);
    apply(6'h17, 32'h1234, 32'h0, 5'd0, 32'h0000_BEEF, 32'h0000_CAFE);
    check("mthi_hi", HI_OUT, 32'h1234);
    check("mthi_lo", LO_OUT, 32'h0000_CAFE);
    apply(6'h18, 32'h5678, 32'h0, 5'd0, 32'h0000_BEEF, 32'h0000_CAFE);
    check("mtlo_lo", LO_OUT, 32'h5678);
    check("mtlo_hi", HI_OUT, 32'h0000_BEEF);
    apply(6'h19, 32'hDEAD_0001, 32'h0BAD_0002, 5'd0, 32'h0, 32'h0);
    check("passa", aluResult, 32'hDEAD_0001);
    apply(6'h1A, 32'hDEAD_0001, 32'h0BAD_0002, 5'd0, 32'h0, 32'h0);
    check("passb", aluResult, 32'h0BAD_0002);
    apply(6'h1B, 32'hFFFF_FFFE, 32'h3, 5'd0, 32'h5555_5555, 32'h6666_6666);
    check("mul_res", aluResult, 32'hFFFF_FFFA);
    check("mul_hi", HI_OUT, 32'h5555_5555);
    check("mul_lo", LO_OUT, 32'h6666_6666);

    apply(6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h7777_7777, 32'h8888_8888);
    check("code3f_res", aluResult, 32'h0);
    check("code3f_hi", HI_OUT, 32'h7777_7777);
    check("code3f_lo", LO_OUT, 32'h8888_8888);
    apply(6'h1C, 32'h1, 32'h1, 5'd0, 32'h0, 32'h0);
    check("code1c_res", aluResult, 32'h0);

    next_edge();
    check("final_ovf", {31'h0, Overflow_OUT}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
